// File: rtl/uart_event_gen.sv
// UART receive FIFO with registered one-cycle event strobes for an interrupt controller.
// Optional break detection on event bit 7 is enabled by defining UART_BREAK_DETECT_EN.
module uart_event_gen #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned BREAK_CYCLES   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_frame_err,
    input  logic       rx_parity_err,
    input  logic       rx_line,
    input  logic       tx_busy,
    input  logic       rd_en,
    input  logic [3:0] rx_threshold,
    output logic [7:0] rd_data,
    output logic [4:0] fifo_count,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic [7:0] event_pulses
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [4:0]        DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT_CYCLES + 1);

    localparam int unsigned EV_RX_DATA    = 0;
    localparam int unsigned EV_RX_THRESH  = 1;
    localparam int unsigned EV_RX_TIMEOUT = 2;
    localparam int unsigned EV_RX_OVERRUN = 3;
    localparam int unsigned EV_FRAME_ERR  = 4;
    localparam int unsigned EV_PARITY_ERR = 5;
    localparam int unsigned EV_TX_DONE    = 6;
    localparam int unsigned EV_BREAK      = 7;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]        count_q, count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              txb_q, txb_d;
    logic [7:0]        ev_q, ev_d;

    logic empty_w, full_w, push_w, pop_w, idle_clr_w, brk_fire_w;
    logic [4:0] thr_w;

    always_comb begin
        empty_w    = (count_q == 5'd0);
        full_w     = (count_q == DEPTH_C);
        pop_w      = rd_en && !empty_w;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
        push_w     = rx_valid && (!full_w || rd_en);
        thr_w      = {1'b0, rx_threshold};

        wr_ptr_d   = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + 5'(push_w) - 5'(pop_w);

        idle_clr_w = push_w || pop_w || empty_w;
        if (idle_clr_w) begin
            idle_d = '0;
        end else if (idle_q == IDLE_SAT) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        txb_d = tx_busy;

        ev_d                = '0;
        ev_d[EV_RX_DATA]    = push_w;
        ev_d[EV_RX_THRESH]  = (rx_threshold != 4'd0) && (count_q < thr_w) && (count_d >= thr_w);
        // Counter parks one above the fire value, so this matches only once per idle stretch.
        ev_d[EV_RX_TIMEOUT] = (idle_q == IDLE_FIRE);
        ev_d[EV_RX_OVERRUN] = rx_valid && full_w && !rd_en;
        ev_d[EV_FRAME_ERR]  = rx_valid && rx_frame_err;
        ev_d[EV_PARITY_ERR] = rx_valid && rx_parity_err;
        ev_d[EV_TX_DONE]    = txb_q && !tx_busy;
        ev_d[EV_BREAK]      = brk_fire_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idle_q   <= '0;
            txb_q    <= 1'b0;
            ev_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idle_q   <= idle_d;
            txb_q    <= txb_d;
            ev_q     <= ev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w && !rst) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef UART_BREAK_DETECT_EN
    localparam int unsigned BRK_W = $clog2(BREAK_CYCLES + 1);
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_CYCLES - 1);
    localparam logic [BRK_W-1:0] BRK_SAT  = BRK_W'(BREAK_CYCLES);

    logic [BRK_W-1:0] brk_q, brk_d;

    always_comb begin
        if (rx_line) begin
            brk_d = '0;
        end else if (brk_q == BRK_SAT) begin
            brk_d = brk_q;
        end else begin
            brk_d = brk_q + BRK_W'(1);
        end
        brk_fire_w = !rx_line && (brk_q == BRK_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q <= '0;
        end else begin
            brk_q <= brk_d;
        end
    end
`else
    logic unused_rx_line;
    assign unused_rx_line = rx_line;
    assign brk_fire_w     = 1'b0;
`endif

    assign rd_data      = mem_q[rd_ptr_q];
    assign fifo_count   = count_q;
    assign fifo_empty   = empty_w;
    assign fifo_full    = full_w;
    assign event_pulses = ev_q;

endmodule

// File: tb/tb_uart_event_gen.sv
// Self-checking bench for uart_event_gen: directed scenarios then randomized traffic,
// checked each cycle against a queue-based reference model.
module tb_uart_event_gen;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;
    localparam int unsigned BRK   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_frame_err = 1'b0;
    logic       rx_parity_err = 1'b0;
    logic       rx_line = 1'b1;
    logic       tx_busy = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rx_threshold = '0;
    logic [7:0] rd_data;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] event_pulses;

    uart_event_gen #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .BREAK_CYCLES  (BRK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_line      (rx_line),
        .tx_busy      (tx_busy),
        .rd_en        (rd_en),
        .rx_threshold (rx_threshold),
        .rd_data      (rd_data),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .event_pulses (event_pulses)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    int         idle_len = 0;
    bit         tx_prev  = 1'b0;
    int         low_run  = 0;

    bit         cur_line = 1'b1;
    bit         cur_busy = 1'b0;
    logic [3:0] cur_th   = '0;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d,
                        input bit fe, input bit pe, input bit rd);
        logic [7:0] ev;
        int  prev;
        bit  push, pop, full;
        ev            = '0;
        rst           = r;
        rx_valid      = v;
        rx_data       = d;
        rx_frame_err  = fe;
        rx_parity_err = pe;
        rd_en         = rd;
        rx_line       = cur_line;
        tx_busy       = cur_busy;
        rx_threshold  = cur_th;
        if (r) begin
            q.delete();
            idle_len = 0;
            tx_prev  = 1'b0;
            low_run  = 0;
        end else begin
            prev = q.size();
            full = (prev == DEPTH);
            pop  = rd && (prev != 0);
            push = v && (!full || rd);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
            ev[0] = push;
            ev[1] = (cur_th != 0) && (prev < int'(cur_th)) && (q.size() >= int'(cur_th));
            ev[2] = (idle_len == TMO);
            idle_len = (push || pop || prev == 0) ? 0 : idle_len + 1;
            ev[3] = v && full && !rd;
            ev[4] = v && fe;
            ev[5] = v && pe;
            ev[6] = tx_prev && !cur_busy;
            tx_prev = cur_busy;
            low_run = cur_line ? 0 : low_run + 1;
`ifdef UART_BREAK_DETECT_EN
            ev[7] = !cur_line && (low_run == BRK);
`endif
        end
        @(posedge clk);
        #1;
        chk("events", 32'(event_pulses), 32'(ev));
        chk("count", 32'(fifo_count), 32'(q.size()));
        chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    task automatic push_b(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_b();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int first_at, npulse;
        logic [7:0] head;

        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        chk("reset_events", 32'(event_pulses), 32'h0);
        chk("reset_empty", 32'(fifo_empty), 32'h1);

        // Threshold crossing on third push
        cur_th = 4'd3;
        push_b(8'h11);
        push_b(8'h22);
        push_b(8'h33);
        chk("thresh_bit", 32'(event_pulses[1]), 32'h1);
        chk("thresh_count", 32'(fifo_count), 32'd3);
        chk("thresh_head", 32'(rd_data), 32'h11);
        pop_b(); pop_b(); pop_b();
        pop_b();
        chk("pop_empty_count", 32'(fifo_count), 32'd0);
        cur_th = 4'd0;

        // Overrun at full, then full push with simultaneous pop
        for (int i = 0; i < DEPTH; i++) push_b(8'hA0 + 8'(i));
        chk("full_flag", 32'(fifo_full), 32'h1);
        push_b(8'hEE);
        chk("overrun_bit", 32'(event_pulses[3]), 32'h1);
        chk("overrun_count", 32'(fifo_count), 32'd8);
        chk("overrun_head", 32'(rd_data), 32'hA0);
        step(1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        chk("pushpop_no_overrun", 32'(event_pulses[3]), 32'h0);
        chk("pushpop_count", 32'(fifo_count), 32'd8);
        chk("pushpop_head", 32'(rd_data), 32'hA1);
        for (int i = 0; i < DEPTH; i++) pop_b();

        // RX timeout, twice
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 1) pop_b();
            push_b(8'h5A + 8'(rep));
            first_at = -1;
            npulse   = 0;
            for (int i = 1; i <= 40; i++) begin
                nop();
                if (event_pulses[2]) begin
                    npulse++;
                    if (first_at < 0) first_at = i;
                end
            end
            chk("timeout_at", 32'(first_at), 32'd17);
            chk("timeout_once", 32'(npulse), 32'd1);
        end
        pop_b();

        // Error flags still store the byte
        step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        chk("err_bits", 32'(event_pulses & 8'h31), 32'h31);
        chk("err_stored", 32'(rd_data), 32'hC3);
        pop_b();

        // TX done edge
        cur_busy = 1'b1; nop(); nop();
        cur_busy = 1'b0; nop();
        chk("tx_done", 32'(event_pulses[6]), 32'h1);
        nop();
        chk("tx_done_once", 32'(event_pulses[6]), 32'h0);

        // Break detection, twice with re-arm
        for (int rep = 0; rep < 2; rep++) begin
            npulse = 0;
            cur_line = 1'b0;
            for (int i = 0; i < BRK + 10; i++) begin
                nop();
                if (event_pulses[7]) npulse++;
            end
            cur_line = 1'b1;
            nop();
`ifdef UART_BREAK_DETECT_EN
            chk("break_pulses", 32'(npulse), 32'd1);
`else
            chk("break_pulses", 32'(npulse), 32'd0);
`endif
        end

        // Reset mid-operation with 5 bytes queued
        for (int i = 0; i < 5; i++) push_b(8'h40 + 8'(i));
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_events", 32'(event_pulses), 32'h0);
        nop();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) cur_th = 4'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) cur_busy = ~cur_busy;
            cur_line = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) begin
                for (int k = 0; k < TMO + 4; k++) nop();
            end else begin
                head = 8'($urandom);
                step($urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0, head,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
